// File: rtl/wb_grf.sv
// wb_grf: write-back stage register file with sub-word load extraction,
// link-data formation, same-cycle write-through bypass and a retirement counter.
module wb_grf #(
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_W,
  input  logic [31:0] Instr_W,
  input  logic [4:0]  WriteReg_W,
  input  logic        RegWrite_W,
  input  logic [1:0]  WDSel_W,
  input  logic [2:0]  LoadType_W,
  input  logic [31:0] ALUOut_W,
  input  logic [31:0] DMOut_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic [31:0] RetireCnt
);

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_DM   = 2'd1,
    WD_LINK = 2'd2,
    WD_RSVD = 2'd3
  } wd_sel_e;

  logic [31:0] regs [0:31];
  logic [31:0] dm_ext;
  logic [31:0] byte_shift;
  logic [7:0]  dm_byte;
  logic [15:0] dm_half;
  logic        we;
  logic        hit1;
  logic        hit2;

  // Extract and extend the addressed byte/half from the aligned DM word.
  always_comb begin
    byte_shift = DMOut_W >> {ALUOut_W[1:0], 3'b000};
    dm_byte    = byte_shift[7:0];
    dm_half    = ALUOut_W[1] ? DMOut_W[31:16] : DMOut_W[15:0];
    case (load_type_e'(LoadType_W))
      LD_B:    dm_ext = {{24{dm_byte[7]}}, dm_byte};
      LD_BU:   dm_ext = {24'd0, dm_byte};
      LD_H:    dm_ext = {{16{dm_half[15]}}, dm_half};
      LD_HU:   dm_ext = {16'd0, dm_half};
      default: dm_ext = DMOut_W;
    endcase
  end

  // Select write-back data; the reserved encoding yields zero.
  always_comb begin
    case (wd_sel_e'(WDSel_W))
      WD_ALU:  WD_W = ALUOut_W;
      WD_DM:   WD_W = dm_ext;
      WD_LINK: WD_W = PC_W + LINK_OFFSET;
      default: WD_W = '0;
    endcase
  end

  assign we = RegWrite_W && (WriteReg_W != 5'd0);

  // Register array: async clear, register 0 never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we) begin
      regs[WriteReg_W] <= WD_W;
    end
  end

  // Retirement counter: every non-bubble instruction, wraps modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RetireCnt <= '0;
    end else if (Instr_W != 32'd0) begin
      RetireCnt <= RetireCnt + 32'd1;
    end
  end

  // Read ports with write-through bypass, applied independently per port.
  always_comb begin
    hit1 = RegWrite_W && (WriteReg_W == A1) && (A1 != 5'd0);
    hit2 = RegWrite_W && (WriteReg_W == A2) && (A2 != 5'd0);
    RD1  = hit1 ? WD_W : ((A1 == 5'd0) ? '0 : regs[A1]);
    RD2  = hit2 ? WD_W : ((A2 == 5'd0) ? '0 : regs[A2]);
  end

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 SHALL have parameter LINK_OFFSET, default 32'd8: value added to PC_W to form the link write data.
REQ-002 SHALL have port clk, input, 1: the single clock; every state change is on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low; 0 clears all state immediately.
REQ-004 SHALL have port PC_W, input, 32: PC of the instruction in the W stage.
REQ-005 SHALL have port Instr_W, input, 32: instruction word in the W stage; 0 marks a bubble.
REQ-006 SHALL have port WriteReg_W, input, 5: destination register number.
REQ-007 SHALL have port RegWrite_W, input, 1: write enable from W-stage control.
REQ-008 SHALL have port WDSel_W, input, 2: write-data source; 0 ALUOut, 1 extended DM data, 2 PC_W+LINK_OFFSET, 3 reserved.
REQ-009 SHALL have port LoadType_W, input, 3: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; others treated as lw.
REQ-010 SHALL have port ALUOut_W, input, 32: ALU result; bits [1:0] give the byte offset for sub-word loads.
REQ-011 SHALL have port DMOut_W, input, 32: raw aligned data-memory word.
REQ-012 SHALL have ports A1 and A2, input, 5 each: D-stage read addresses.
REQ-013 SHALL have ports RD1 and RD2, output, 32 each: read data for A1 and A2.
REQ-014 SHALL have port WD_W, output, 32: selected write-back data (combinational), exposed for forwarding.
REQ-015 SHALL have port RetireCnt, output, 32: count of retired non-bubble instructions.

Function
REQ-016 SHALL hold 32 x 32-bit registers; register 0 reads 0 always and is never written.
REQ-017 SHALL extract the DM data by LoadType_W and ALUOut_W[1:0]: lb/lbu select byte [8*off+7:8*off], sign- or zero-extended; lh/lhu select half [16*off[1]+15:16*off[1]], sign- or zero-extended; lw passes the word through.
REQ-018 SHALL ignore ALUOut_W[0] for halfword loads and ignore the offset entirely for lw; no misalignment fault is raised.
REQ-019 SHALL form WD_W from WDSel_W; when WDSel_W is 3, WD_W SHALL be 0.
REQ-020 SHALL write WD_W to register WriteReg_W on the rising edge when RegWrite_W=1, WriteReg_W!=0 and reset=1.
REQ-021 SHALL drive RDn from the array combinationally, with write-through bypass: if RegWrite_W=1, WriteReg_W==An and An!=0, RDn SHALL equal WD_W in the same cycle.
REQ-022 SHALL apply bypass independently on both read ports; when A1==A2, RD1 and RD2 SHALL match.
REQ-023 SHALL increment RetireCnt by 1, modulo 2^32, on each rising edge where Instr_W!=0; it wraps from 0xFFFFFFFF to 0.
REQ-024 SHALL count a retirement whether or not RegWrite_W is set.
REQ-025 SHALL have no latency beyond one edge: data written at edge N SHALL be visible on RDn from array storage after edge N.

Reset
REQ-026 SHALL, while reset=0, clear all 32 registers and RetireCnt to 0 asynchronously, without waiting for clk.
REQ-027 SHALL suppress writes and counting on any edge where reset=0; a write coinciding with reset assertion is lost.
REQ-028 SHALL force RD1, RD2 and RetireCnt to 0 during reset, except for any bypass term; WD_W SHALL remain combinational from its inputs.
REQ-029 SHALL resume normal operation on the first rising edge after reset returns to 1.

Verification
REQ-030 Reset then set A1=5 -> RD1=0 and RetireCnt=0.
REQ-031 Write RegWrite=1, WriteReg=8, WDSel=0, ALUOut=0x12345678, A1=8 in the same cycle -> RD1=0x12345678 before the edge (bypass), and still 0x12345678 after the edge with the write input removed.
REQ-032 Sub-word loads with DMOut=0x80FF7F01: lb, offset 3 -> 0xFFFFFF80; lbu, offset 3 -> 0x00000080; lh, offset 2 -> 0xFFFF80FF; lhu, offset 0 -> 0x00007F01.
REQ-033 Link write with WDSel=2, PC_W=0x00003000, WriteReg=31 -> register 31 reads 0x00003008 afterwards; the same write to WriteReg=0 -> RD for A=0 stays 0, with no bypass.
REQ-034 Preload RetireCnt to 0xFFFFFFFE via a run of non-zero Instr_W, then apply two more non-zero instructions and one bubble (Instr_W=0) -> counts 0xFFFFFFFF, then 0, then 0 held.
REQ-035 Assert reset low mid-cycle after registers are written -> RD1, RD2 and RetireCnt read 0 before the next clk edge; after release, the first write succeeds.
